// File: rtl/alarm_set_multi.sv
// alarm_set_multi: bank of NUM_ALARMS BCD HH:MM alarms, edited one slot at a time with u/d/l/r buttons
// Ports: clk, reset (sync, active-high); spdt2 edit switch; slot selects the slot to edit/read (latched on spdt2 rise);
//        push_u/d/l/r debounced buttons; sel one-hot cursor; alarm working/committed value; alarm_all flat bank;
//        finish2 one-cycle commit pulse; busy high while editing.
// Optional: define ALARM_EDIT_CANCEL_EN to let l+r pressed together abort an edit.
module alarm_set_multi #(
  parameter int NUM_ALARMS = 4,
  parameter int SLOT_W = 2,
  parameter logic [15:0] DEFAULT_ALARM = 16'h1630
) (
  input  logic clk,
  input  logic reset,
  input  logic spdt2,
  input  logic [SLOT_W-1:0] slot,
  input  logic push_u,
  input  logic push_d,
  input  logic push_l,
  input  logic push_r,
  output logic [3:0] sel,
  output logic [15:0] alarm,
  output logic [16*NUM_ALARMS-1:0] alarm_all,
  output logic finish2,
  output logic busy
);
  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
`ifdef ALARM_EDIT_CANCEL_EN
    , WAIT_LOW
`endif
  } state_t;
  state_t r_state, w_next;
  logic [15:0] r_bank [NUM_ALARMS];
  logic [15:0] r_work, w_work_n;
  logic [3:0] r_sel, w_sel_n;
  logic [SLOT_W-1:0] r_cur, w_slot_c;
  logic r_spdt2_q, r_u_q, r_d_q, r_l_q, r_r_q;
  logic w_rise, w_ev_u, w_ev_d, w_ev_l, w_ev_r, w_up, w_dn;
  logic [3:0] w_th, w_oh, w_tm, w_om, w_th_n, w_oh_s, w_oh_n;
  function automatic logic [3:0] step(input logic [3:0] d, input logic [3:0] m, input logic up, input logic dn);
    return up ? (d == m ? 4'd0 : d + 4'd1) : dn ? (d == 4'd0 ? m : d - 4'd1) : d;
  endfunction
  assign w_rise = spdt2 & ~r_spdt2_q;
  assign w_ev_u = push_u & ~r_u_q;
  assign w_ev_d = push_d & ~r_d_q;
  assign w_ev_l = push_l & ~r_l_q;
  assign w_ev_r = push_r & ~r_r_q;
  assign w_slot_c = (int'(slot) >= NUM_ALARMS) ? SLOT_W'(NUM_ALARMS - 1) : slot;
  assign busy = (r_state == EDIT);
  assign finish2 = (r_state == COMMIT);
  assign sel = busy ? r_sel : 4'b0000;
  assign alarm = busy ? r_work : r_bank[r_cur];
  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_all
    assign alarm_all[16*k +: 16] = r_bank[k];
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_rise ? EDIT : IDLE;
`ifdef ALARM_EDIT_CANCEL_EN
      EDIT: w_next = !spdt2 ? COMMIT : (w_ev_l & w_ev_r) ? WAIT_LOW : EDIT;
      WAIT_LOW: w_next = spdt2 ? WAIT_LOW : IDLE;
`else
      EDIT: w_next = spdt2 ? EDIT : COMMIT;
`endif
      default: w_next = IDLE;
    endcase
  end
  // Digit edits use the cursor as it stood at the start of the cycle; the hour clamp
  // looks at the new tens-hour so 1x -> 2x never leaves an invalid 24..29.
  always_comb begin
    {w_th, w_oh, w_tm, w_om} = r_work;
    w_up = w_ev_u & ~w_ev_d;
    w_dn = w_ev_d & ~w_ev_u;
    w_th_n = step(w_th, 4'd2, w_up & r_sel[3], w_dn & r_sel[3]);
    w_oh_s = step(w_oh, (w_th == 4'd2) ? 4'd3 : 4'd9, w_up & r_sel[2], w_dn & r_sel[2]);
    w_oh_n = (w_th_n == 4'd2 && w_oh_s > 4'd3) ? 4'd3 : w_oh_s;
    w_work_n = {w_th_n, w_oh_n, step(w_tm, 4'd5, w_up & r_sel[1], w_dn & r_sel[1]),
                step(w_om, 4'd9, w_up & r_sel[0], w_dn & r_sel[0])};
    w_sel_n = (w_ev_r & ~w_ev_l) ? {r_sel[0], r_sel[3:1]} :
              (w_ev_l & ~w_ev_r) ? {r_sel[2:0], r_sel[3]} : r_sel;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) r_bank[i] <= DEFAULT_ALARM;
      r_work <= DEFAULT_ALARM;
      r_sel <= 4'b1000;
      r_cur <= '0;
      {r_spdt2_q, r_u_q, r_d_q, r_l_q, r_r_q} <= '0;
    end else begin
      {r_spdt2_q, r_u_q, r_d_q, r_l_q, r_r_q} <= {spdt2, push_u, push_d, push_l, push_r};
      if (r_state == IDLE && w_rise) begin
        r_cur <= w_slot_c;
        r_work <= r_bank[w_slot_c];
        r_sel <= 4'b1000;
      end else if (r_state == EDIT && spdt2) begin
        r_work <= w_work_n;
        r_sel <= w_sel_n;
      end
      if (r_state == EDIT && !spdt2) r_bank[r_cur] <= r_work;
    end
  end
endmodule

// File: tb/tb_alarm_set_multi.sv
// tb_alarm_set_multi: directed table plus hand sequences for alarm_set_multi
module tb_alarm_set_multi;
  logic clk = 1'b0, reset = 1'b1, spdt2 = 1'b0;
  logic [1:0] slot = 2'd0;
  logic push_u = 1'b0, push_d = 1'b0, push_l = 1'b0, push_r = 1'b0;
  logic [3:0] sel;
  logic [15:0] alarm;
  logic [63:0] alarm_all;
  logic finish2, busy;
  int n_tests = 0, n_fail = 0;
  alarm_set_multi dut (
    .clk(clk), .reset(reset), .spdt2(spdt2), .slot(slot),
    .push_u(push_u), .push_d(push_d), .push_l(push_l), .push_r(push_r),
    .sel(sel), .alarm(alarm), .alarm_all(alarm_all), .finish2(finish2), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0] in;
    logic [3:0] sel;
    logic [15:0] al;
    logic [1:0] fb;
    logic [15:0] b0;
  } vec_t;
  vec_t v[16];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input logic sp, input logic [1:0] sl, input logic [3:0] b);
    @(negedge clk);
    spdt2 = sp;
    slot = sl;
    {push_u, push_d, push_l, push_r} = b;
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [1:0] sl, input logic [3:0] b);
    step(1'b1, sl, b);
    step(1'b1, sl, 4'b0000);
  endtask
  initial begin
    v[0]  = '{7'b1_00_0000, 4'b1000, 16'h1630, 2'b01, 16'h1630};
    v[1]  = '{7'b1_00_0100, 4'b1000, 16'h0630, 2'b01, 16'h1630};
    v[2]  = '{7'b1_00_0001, 4'b0100, 16'h0630, 2'b01, 16'h1630};
    v[3]  = '{7'b1_00_1000, 4'b0100, 16'h0730, 2'b01, 16'h1630};
    v[4]  = '{7'b1_00_0000, 4'b0100, 16'h0730, 2'b01, 16'h1630};
    v[5]  = '{7'b1_00_1000, 4'b0100, 16'h0830, 2'b01, 16'h1630};
    v[6]  = '{7'b1_00_0000, 4'b0100, 16'h0830, 2'b01, 16'h1630};
    v[7]  = '{7'b1_00_1000, 4'b0100, 16'h0930, 2'b01, 16'h1630};
    v[8]  = '{7'b1_00_0001, 4'b0010, 16'h0930, 2'b01, 16'h1630};
    v[9]  = '{7'b1_00_0000, 4'b0010, 16'h0930, 2'b01, 16'h1630};
    v[10] = '{7'b1_00_0001, 4'b0001, 16'h0930, 2'b01, 16'h1630};
    v[11] = '{7'b1_00_0100, 4'b0001, 16'h0939, 2'b01, 16'h1630};
    v[12] = '{7'b1_00_0000, 4'b0001, 16'h0939, 2'b01, 16'h1630};
    v[13] = '{7'b1_00_0100, 4'b0001, 16'h0938, 2'b01, 16'h1630};
    v[14] = '{7'b0_00_0000, 4'b0000, 16'h0938, 2'b10, 16'h0938};
    v[15] = '{7'b0_00_0000, 4'b0000, 16'h0938, 2'b00, 16'h0938};
    step(1'b0, 2'd0, 4'b0000);
    chk("rst_sel", 64'(sel), 64'(4'b0000));
    chk("rst_fb", 64'({finish2, busy}), 64'(2'b00));
    chk("rst_alarm", 64'(alarm), 64'(16'h1630));
    chk("rst_all", alarm_all, 64'h1630_1630_1630_1630);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(v[i].in[6], v[i].in[5:4], v[i].in[3:0]);
      chk($sformatf("v%0d_sel", i), 64'(sel), 64'(v[i].sel));
      chk($sformatf("v%0d_alarm", i), 64'(alarm), 64'(v[i].al));
      chk($sformatf("v%0d_fin_busy", i), 64'({finish2, busy}), 64'(v[i].fb));
      chk($sformatf("v%0d_bank0", i), 64'(alarm_all[15:0]), 64'(v[i].b0));
    end
    chk("seq1_all", alarm_all, 64'h1630_1630_1630_0938);
    // slot 2 -> 19:00, then tens-hour up clamps to 23:00 and wraps to 03:00
    step(1'b1, 2'd2, 4'b0000);
    chk("s2_enter", 64'(alarm), 64'(16'h1630));
    press(2'd2, 4'b0001);
    for (int i = 0; i < 3; i++) press(2'd2, 4'b1000);
    press(2'd2, 4'b0001);
    for (int i = 0; i < 3; i++) press(2'd2, 4'b0100);
    chk("s2_1900", 64'(alarm), 64'(16'h1900));
    step(1'b0, 2'd2, 4'b0000);
    chk("s2_fin", 64'(finish2), 64'(1'b1));
    step(1'b0, 2'd2, 4'b0000);
    chk("s2_bank_1900", 64'(alarm_all[47:32]), 64'(16'h1900));
    step(1'b1, 2'd2, 4'b0000);
    chk("s2_reenter", 64'(alarm), 64'(16'h1900));
    press(2'd2, 4'b1000);
    chk("s2_clamp", 64'(alarm), 64'(16'h2300));
    press(2'd2, 4'b1000);
    chk("s2_wrap", 64'(alarm), 64'(16'h0300));
    step(1'b0, 2'd2, 4'b0000);
    step(1'b0, 2'd2, 4'b0000);
    chk("s2_bank_0300", alarm_all, 64'h1630_0300_1630_0938);
    // slot 1: left wrap, held button, u&d, vertical+horizontal together
    step(1'b1, 2'd1, 4'b0000);
    step(1'b1, 2'd1, 4'b0010);
    chk("s1_lwrap", 64'(sel), 64'(4'b0001));
    for (int i = 0; i < 10; i++) step(1'b1, 2'd1, 4'b1000);
    step(1'b1, 2'd1, 4'b0000);
    chk("s1_hold", 64'(alarm), 64'(16'h1631));
    press(2'd1, 4'b1100);
    chk("s1_ud", 64'(alarm), 64'(16'h1631));
    step(1'b1, 2'd1, 4'b1001);
    chk("s1_ur_sel", 64'(sel), 64'(4'b1000));
    chk("s1_ur_alarm", 64'(alarm), 64'(16'h1632));
    step(1'b0, 2'd1, 4'b0000);
    chk("s1_fin", 64'({finish2, busy}), 64'(2'b10));
    step(1'b0, 2'd1, 4'b0000);
    chk("s1_fin_once", 64'(finish2), 64'(1'b0));
    chk("s1_bank", alarm_all, 64'h1630_0300_1632_0938);
    // reset mid-edit discards the working value
    step(1'b1, 2'd0, 4'b0000);
    chk("r_enter", 64'(alarm), 64'(16'h0938));
    press(2'd0, 4'b0100);
    chk("r_clamp_dn", 64'(alarm), 64'(16'h2338));
    reset = 1'b1;
    step(1'b0, 2'd0, 4'b0000);
    reset = 1'b0;
    chk("r_bank", alarm_all, 64'h1630_1630_1630_1630);
    chk("r_sel_fb", 64'({sel, finish2, busy}), 64'(6'b0));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd0, 4'b0000);
      chk($sformatf("r_nofin%0d", i), 64'(finish2), 64'(1'b0));
    end
    // l&r together: cancel when enabled, otherwise a no-op
    step(1'b1, 2'd3, 4'b0000);
    press(2'd3, 4'b1000);
    chk("c_edit", 64'(alarm), 64'(16'h2330));
    step(1'b1, 2'd3, 4'b0011);
`ifdef ALARM_EDIT_CANCEL_EN
    chk("c_lr_sel_busy", 64'({sel, busy}), 64'(5'b0));
`else
    chk("c_lr_sel_busy", 64'({sel, busy}), 64'(5'b1000_1));
    chk("c_lr_alarm", 64'(alarm), 64'(16'h2330));
`endif
    step(1'b1, 2'd3, 4'b0000);
    step(1'b0, 2'd3, 4'b0000);
`ifdef ALARM_EDIT_CANCEL_EN
    chk("c_fin", 64'(finish2), 64'(1'b0));
    step(1'b0, 2'd3, 4'b0000);
    chk("c_bank", alarm_all, 64'h1630_1630_1630_1630);
`else
    chk("c_fin", 64'(finish2), 64'(1'b1));
    step(1'b0, 2'd3, 4'b0000);
    chk("c_bank", alarm_all, 64'h2330_1630_1630_1630);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_set_multi.md
Name: alarm_set_multi

Overview:
- Parametrised successor to the single-alarm setter: holds NUM_ALARMS independent HH:MM alarms in BCD and lets the user edit one slot at a time with u/d/l/r push buttons while spdt2 is high.
- Commits the edit on spdt2 falling and reports the committed values to the alarm comparator and display mux.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16).
- SLOT_W, 2, width of slot index; must satisfy 2**SLOT_W >= NUM_ALARMS.
- DEFAULT_ALARM, 16'h1630, BCD HHMM loaded into every slot at reset.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- spdt2  input  1  edit switch; high = edit mode.
- slot  input  SLOT_W  slot to edit/read; sampled only on spdt2 rising edge.
- push_u, push_d, push_l, push_r  input  1 each  level button inputs, already debounced.
- sel  output  4  one-hot cursor; bit3 = tens-hour … bit0 = ones-minute; 0 when not editing.
- alarm  output  16  BCD HHMM: the working value while editing, else bank[slot].
- alarm_all  output  16*NUM_ALARMS  flat bank; slot k at bits [16k+15:16k].
- finish2  output  1  one-cycle pulse after each commit.
- busy  output  1  high while in EDIT.

Behaviour:
- Reset: one clock, synchronous and active-high.
  - All slots = DEFAULT_ALARM; state IDLE; sel=0; finish2=0; busy=0; edge registers cleared.
  - Reset wins over every other event. Reset mid-edit discards the working value with no commit and no finish2.
- Buttons are rising-edge detected: event = push & ~push_q. Holding a button produces one event.
- FSM IDLE -> EDIT:
  - On spdt2 rising, latch slot into cur_slot; working = bank[cur_slot]; sel = 4'b1000.
  - Slot values >= NUM_ALARMS clamp to NUM_ALARMS-1.
- EDIT -> COMMIT:
  - On spdt2 low, bank[cur_slot] <= working; finish2 = 1 for exactly the following cycle; busy drops.
  - Button events in the cycle spdt2 falls are ignored.
- COMMIT -> IDLE unconditionally after 1 cycle.
- Events in IDLE/COMMIT are ignored.
- Cursor (EDIT):
  - push_r shifts sel right: 1000 -> 0100 -> 0010 -> 0001 -> wrap to 1000.
  - push_l shifts left, with the symmetric wrap.
- Digit edit (EDIT), applied to the digit under the cursor as it stood before any move in the same cycle:
  - Tens-hour 0..2: up wraps 2->0; down wraps 0->2.
  - Ones-hour 0..9, or 0..3 when tens-hour=2: up wraps max->0; down wraps 0->max.
  - Tens-minute 0..5; ones-minute 0..9; wrap as above.
  - Hour clamp: whenever tens-hour becomes 2 and ones-hour > 3, ones-hour is forced to 3 in the same update.
- Simultaneous events:
  - u&d together: no digit change.
  - l&r together: no cursor move, except as described under the optional feature.
  - Vertical plus horizontal in the same cycle: both apply; the digit change uses the old cursor.
- Latency: a digit or cursor update is visible on outputs the cycle after the edge where the press is first sampled.
- alarm_all always shows committed values only, never the working value.
- Invariant: all values stay valid BCD in 00:00..23:59.

Optional Feature:
- Macro ALARM_EDIT_CANCEL_EN.
- Defined:
  - push_l&push_r rising together in EDIT aborts the edit: the bank is unchanged and state returns to a WAIT_LOW state (sel=0, busy=0).
  - When spdt2 later falls, no commit happens and finish2 stays 0; state returns to IDLE.
- Undefined: l&r together is a no-op, and WAIT_LOW does not exist.

Test Plan:
- Reset, slot=0, spdt2 rises -> alarm=16'h1630, sel=4'b1000.
- Edit sequence d; r; u x3; r; r; d x2; then spdt2 low -> finish2 single pulse; alarm_all[15:0]=16'h0938; slots 1..3 remain 16'h1630.
- Slot 2 set to 19:00, re-enter, u on tens-hour -> 16'h2300 (clamp); u again -> 16'h0300.
- Cursor at 1000, push_l -> 0001; held push_u for 10 cycles -> ones-minute increments exactly once; u&d together -> no change.
- Reset asserted mid-edit after changes -> bank all 16'h1630, finish2 never pulses, sel=0.
- With ALARM_EDIT_CANCEL_EN: change digits, press l&r, drop spdt2 -> bank unchanged, finish2=0. Without the macro: same stimulus commits the changed value.
